// File: rtl/l2_line_responder.sv
// Next-level line responder: in-order 2-deep request queue with fixed access latency,
// a tagged line store for writebacks, and read/write statistics.
module l2_line_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 64
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [25:0]   req_add,
  input  logic [511:0]  req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [25:0]   rsp_add,
  output logic [511:0]  rsp_data,
  output logic [31:0]   reads,
  output logic [31:0]   writes,
  output logic          busy
);

  localparam int unsigned AW = 26;
  localparam int unsigned LW = 512;
  localparam int unsigned SW = 32;
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LOAD = CW'(LATENCY - 1);

  typedef struct packed {
    logic          write;
    logic [AW-1:0] add;
    logic [LW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            head_q, head_d;
  logic [1:0]      count_q, count_d;
  entry_t          q_mem [2];
  entry_t          head;
  logic            tail;

  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    tag_mem  [DEPTH];
  logic [LW-1:0]    line_mem [DEPTH];

  logic            accept_c, pop_c, store_c, hit_c;
  logic [IW-1:0]   idx_c;
  logic [LW-1:0]   fill_c;
  logic            rsp_valid_d;
  logic [AW-1:0]   rsp_add_d;
  logic [LW-1:0]   rsp_data_d;
  logic [SW-1:0]   reads_d, writes_d;

  assign accept_c = req_valid && req_ready;
  assign head     = q_mem[head_q];
  assign tail     = head_q ^ count_q[0];
  assign idx_c    = head.add[IW-1:0];
  assign hit_c    = valid_q[idx_c] && (tag_mem[idx_c] == head.add);
  assign fill_c   = {16{{6'b0, head.add}}};

  // Next-state, queue bookkeeping and response loading.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop_c       = 1'b0;
    store_c     = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_add_d   = rsp_add;
    rsp_data_d  = rsp_data;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = WAIT;
          cnt_d   = LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (head.write) begin
            store_c = 1'b1;
            pop_c   = 1'b1;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_add_d   = head.add;
            rsp_data_d  = hit_c ? line_mem[idx_c] : fill_c;
            state_d     = RESP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          pop_c       = 1'b1;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q;
    if (accept_c && !pop_c)      count_d = count_q + 2'd1;
    else if (!accept_c && pop_c) count_d = count_q - 2'd1;
    head_d = pop_c ? ~head_q : head_q;

    // A retiring head hands over to whatever is still queued, including a same-edge push.
    if (pop_c) begin
      state_d = (count_d != 2'd0) ? WAIT : IDLE;
      cnt_d   = LOAD;
    end

    reads_d  = (accept_c && !req_write) ? reads + SW'(1) : reads;
    writes_d = (accept_c &&  req_write) ? writes + SW'(1) : writes;
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      head_q    <= 1'b0;
      count_q   <= 2'd0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_add   <= '0;
      rsp_data  <= '0;
      reads     <= '0;
      writes    <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      count_q   <= count_d;
      req_ready <= (count_d < 2'd2);
      busy      <= (count_d != 2'd0) || rsp_valid_d;
      rsp_valid <= rsp_valid_d;
      rsp_add   <= rsp_add_d;
      rsp_data  <= rsp_data_d;
      reads     <= reads_d;
      writes    <= writes_d;
      if (store_c) valid_q[idx_c] <= 1'b1;
    end
  end

  // Queue payload and line store carry no reset; validity lives in count_q and valid_q.
  always_ff @(posedge clk) begin
    if (clear && accept_c) q_mem[tail] <= {req_write, req_add, req_data};
    if (clear && store_c) begin
      tag_mem[idx_c]  <= head.add;
      line_mem[idx_c] <= head.data;
    end
  end

endmodule
